// File: rtl/axi_lite_master.sv
// Single-beat AXI-Lite initiator: one local command in, one response out.
// Optional response-wait watchdog enabled by defining AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  output logic              wlast,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

  state_t            state, state_n;
  logic              awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic [ADDR_W-1:0] awaddr_n, araddr_n;
  logic [DATA_W-1:0] wdata_n, rsp_rdata_n;
  logic [1:0]        rsp_resp_n;

  // Every beat is single, so rlast carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast;

  assign wlast = wvalid;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          busy;

  assign busy = (state == WR) || (state == WR_RESP) || (state == RD_ADDR) || (state == RD_DATA);

  // IDLE always precedes WR/RD_ADDR, so clearing there clears on entry.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)           tmo_cnt <= '0;
    else if (state == IDLE) tmo_cnt <= '0;
    else if (busy)          tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_n     = state;
    awvalid_n   = awvalid;
    wvalid_n    = wvalid;
    bready_n    = bready;
    arvalid_n   = arvalid;
    rready_n    = rready;
    awaddr_n    = awaddr;
    araddr_n    = araddr;
    wdata_n     = wdata;
    rsp_rdata_n = rsp_rdata;
    rsp_resp_n  = rsp_resp;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        if (cmd_write) begin
          awaddr_n  = cmd_addr;
          wdata_n   = cmd_wdata;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          bready_n  = 1'b1;
          state_n   = WR;
        end else begin
          araddr_n  = cmd_addr;
          arvalid_n = 1'b1;
          rready_n  = 1'b1;
          state_n   = RD_ADDR;
        end
      end
      WR: begin
        awvalid_n = awvalid && !awready;
        wvalid_n  = wvalid && !wready;
        // bready is already high here, so an early B is taken immediately.
        if (bvalid) begin
          rsp_resp_n  = bresp;
          rsp_rdata_n = '0;
          bready_n    = 1'b0;
          awvalid_n   = 1'b0;
          wvalid_n    = 1'b0;
          state_n     = RESP;
        end else if (!awvalid_n && !wvalid_n) begin
          state_n = WR_RESP;
        end
      end
      WR_RESP: if (bvalid) begin
        rsp_resp_n  = bresp;
        rsp_rdata_n = '0;
        bready_n    = 1'b0;
        state_n     = RESP;
      end
      RD_ADDR: if (arready) begin
        arvalid_n = 1'b0;
        if (rvalid) begin
          rsp_rdata_n = rdata;
          rsp_resp_n  = 2'b00;
          rready_n    = 1'b0;
          state_n     = RESP;
        end else begin
          state_n = RD_DATA;
        end
      end
      RD_DATA: if (rvalid) begin
        rsp_rdata_n = rdata;
        rsp_resp_n  = 2'b00;
        rready_n    = 1'b0;
        state_n     = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    if (busy && state_n != RESP && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      awvalid_n   = 1'b0;
      wvalid_n    = 1'b0;
      bready_n    = 1'b0;
      arvalid_n   = 1'b0;
      rready_n    = 1'b0;
      rsp_resp_n  = 2'b11;
      rsp_rdata_n = '0;
      state_n     = RESP;
    end
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
    end else begin
      state     <= state_n;
      cmd_ready <= (state_n == IDLE);
      rsp_valid <= (state_n == RESP);
      rsp_rdata <= rsp_rdata_n;
      rsp_resp  <= rsp_resp_n;
      awaddr    <= awaddr_n;
      awvalid   <= awvalid_n;
      wdata     <= wdata_n;
      wvalid    <= wvalid_n;
      bready    <= bready_n;
      araddr    <= araddr_n;
      arvalid   <= arvalid_n;
      rready    <= rready_n;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: behavioural AXI-Lite slave with per-channel
// ready delays, a protocol monitor, and hand-computed expected responses.
module tb_axi_lite_master;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready, rvalid, rlast, rready;

  int errs = 0, checks = 0, rsp_cnt = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit early_b = 0, ar_stall = 0;
  logic [31:0] mem [16];

  always #5 aclk = ~aclk;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slave: handshakes are decided at negedge, readies/valids change at posedge+1.
  initial begin : slave
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w, have_ar;
    int c_aw, c_w, c_b, c_ar, c_r;
    logic [31:0] s_addr, s_data, r_addr;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_005A;
    mem[3] = 32'h0000_0077;
    {awready, wready, bvalid, arready, rvalid, rlast} = '0;
    bresp = 2'b00; rdata = '0;
    {have_aw, have_w, have_ar} = '0;
    {c_aw, c_w, c_b, c_ar, c_r} = '0;
    s_addr = '0; s_data = '0; r_addr = '0;
    forever begin
      @(negedge aclk);
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      ar_hs = arvalid && arready; r_hs = rvalid && rready;
      if (aw_hs) begin have_aw = 1; s_addr = awaddr; end
      if (w_hs)  begin have_w = 1;  s_data = wdata;  end
      if (ar_hs) begin have_ar = 1; r_addr = araddr; end
      @(posedge aclk); #1;
      if (!aresetn) begin
        {awready, wready, bvalid, arready, rvalid, rlast} = '0;
        {have_aw, have_w, have_ar} = '0;
        {c_aw, c_w, c_b, c_ar, c_r} = '0;
      end else if (early_b && awvalid && wvalid && !awready && !aw_hs) begin
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
        mem[awaddr[5:2]] = wdata;
      end else begin
        if (aw_hs) begin awready = 0; c_aw = 0; end
        else if (awvalid && !awready) begin if (c_aw >= aw_dly) awready = 1; else c_aw++; end
        if (w_hs) begin wready = 0; c_w = 0; end
        else if (wvalid && !wready) begin if (c_w >= w_dly) wready = 1; else c_w++; end
        if (b_hs) begin bvalid = 0; have_aw = 0; have_w = 0; c_b = 0; end
        else if (have_aw && have_w && !bvalid) begin
          if (c_b >= b_dly) begin bvalid = 1; bresp = 2'b00; mem[s_addr[5:2]] = s_data; end
          else c_b++;
        end
        if (ar_hs) begin arready = 0; c_ar = 0; end
        else if (arvalid && !arready && !ar_stall) begin if (c_ar >= ar_dly) arready = 1; else c_ar++; end
        if (r_hs) begin rvalid = 0; rlast = 0; have_ar = 0; c_r = 0; end
        else if (have_ar && !rvalid && rready) begin
          if (c_r >= r_dly) begin rvalid = 1; rlast = 1; rdata = mem[r_addr[5:2]]; end
          else c_r++;
        end
      end
    end
  end

  // Protocol monitor: valids/readies drop right after their handshake.
  initial begin : monitor
    bit p_aw, p_w, p_ar, p_b, p_r, p_rst;
    {p_aw, p_w, p_ar, p_b, p_r, p_rst} = '0;
    forever begin
      @(negedge aclk);
      if (rsp_valid) rsp_cnt++;
      if (aresetn && p_rst) begin
        if (p_aw) chk("aw_drop", awvalid, 0);
        if (p_w)  chk("w_drop", wvalid, 0);
        if (p_ar) chk("ar_drop", arvalid, 0);
        if (p_b)  chk("b_drop", bready, 0);
        if (p_r)  chk("r_drop", rready, 0);
        if (wvalid)    chk("wlast", wlast, 1);
        if (arvalid)   chk("rready_ar", rready, 1);
        if (rsp_valid) chk("rsp_ovl", cmd_ready, 0);
      end
      p_aw = awvalid && awready; p_w = wvalid && wready; p_ar = arvalid && arready;
      p_b = bvalid && bready; p_r = rvalid && rready; p_rst = aresetn;
    end
  end

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge aclk);
    while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
    if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    d = 'x; r = 'x;
    @(negedge aclk);
    while (!rsp_valid && n < 300) begin @(negedge aclk); n++; end
    if (!rsp_valid) chk("rsp_wait", rsp_valid, 1);
    else begin d = rsp_rdata; r = rsp_resp; end
  endtask

  logic [31:0] d, last_wr;
  logic [1:0]  r;
  int base, n;

  initial begin
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge aclk);
    chk("rst_ctl", {cmd_ready, rsp_valid, awvalid, wvalid, wlast, bready, arvalid, rready}, 8'h00);
    chk("rst_rsp", {rsp_rdata, rsp_resp}, 34'h0);
    aresetn = 1;
    @(negedge aclk);
    chk("idle_ready", cmd_ready, 1);

    // Write 0x41 to 0x4: awready handshake at cycle 2, wready at cycle 4
    aw_dly = 1; w_dly = 3; b_dly = 0;
    base = rsp_cnt;
    issue(1, 32'h4, 32'h41);
    @(negedge aclk);
    chk("wr_c1", {awvalid, wvalid, bready, cmd_ready}, 4'b1110);
    chk("wr_addr", awaddr, 32'h4);
    chk("wr_data", wdata, 32'h41);
    repeat (2) @(negedge aclk);
    chk("wr_c3", {awvalid, wvalid}, 2'b01);
    repeat (2) @(negedge aclk);
    chk("wr_c5", {wvalid, bready, bvalid}, 3'b011);
    wait_rsp(d, r);
    chk("wr_resp", r, 2'b00);
    chk("wr_rdata", d, 32'h0);
    @(negedge aclk);
    chk("wr_pulse", {rsp_valid, cmd_ready}, 2'b01);
    chk("wr_count", rsp_cnt - base, 1);
    chk("wr_mem", mem[1], 32'h41);

    // Read 0x0 -> 0x5A
    aw_dly = 0; w_dly = 0; r_dly = 2;
    issue(0, 32'h0, 32'h0);
    @(negedge aclk);
    chk("rd_c1", {arvalid, rready, awvalid}, 3'b110);
    wait_rsp(d, r);
    chk("rd_data", d, 32'h5A);
    chk("rd_resp", r, 2'b00);

    // Same-cycle AW/W handshake with B while still in WR
    early_b = 1;
    base = rsp_cnt;
    issue(1, 32'h8, 32'hCAFE_0001);
    wait_rsp(d, r);
    chk("eb_resp", r, 2'b00);
    repeat (3) @(negedge aclk);
    chk("eb_count", rsp_cnt - base, 1);
    chk("eb_idle", {cmd_ready, awvalid, wvalid, bready}, 4'b1000);
    early_b = 0;

    // Reset asserted in RD_DATA, then a clean read
    r_dly = 8; ar_dly = 0;
    issue(0, 32'hC, 32'h0);
    repeat (2) @(negedge aclk);
    chk("rst_pre", {arvalid, rready}, 2'b01);
    base = rsp_cnt;
    #2 aresetn = 0;
    #1 chk("rst_mid", {cmd_ready, rsp_valid, awvalid, wvalid, wlast, bready, arvalid, rready}, 8'h00);
    @(negedge aclk);
    aresetn = 1;
    repeat (5) @(negedge aclk);
    chk("rst_norsp", rsp_cnt - base, 0);
    chk("rst_ready", cmd_ready, 1);
    r_dly = 1;
    issue(0, 32'hC, 32'h0);
    wait_rsp(d, r);
    chk("rst_rd", d, 32'h77);
    chk("rst_rd_resp", r, 2'b00);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    ar_stall = 1;
    issue(0, 32'h40, 32'h0);
    n = 1;
    @(negedge aclk);
    while (!rsp_valid && n < 100) begin @(negedge aclk); n++; end
    chk("tmo_cycles", n, 17);
    chk("tmo_resp", rsp_resp, 2'b11);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_bus", {arvalid, rready}, 2'b00);
    ar_stall = 0;
`endif

    // Alternating write/read with random slave delays
    last_wr = '0;
    for (int i = 0; i < 10; i++) begin
      aw_dly = $urandom_range(0, 5); w_dly = $urandom_range(0, 5); b_dly = $urandom_range(0, 5);
      ar_dly = $urandom_range(0, 5); r_dly = $urandom_range(0, 5);
      if (i % 2 == 0) begin
        last_wr = 32'h1000 + 32'(i * 3);
        issue(1, 32'(((i / 2) + 4) * 4), last_wr);
        wait_rsp(d, r);
        chk("b2b_wresp", r, 2'b00);
      end else begin
        issue(0, 32'(((i / 2) + 4) * 4), 32'h0);
        wait_rsp(d, r);
        chk("b2b_rdata", d, last_wr);
        chk("b2b_rresp", r, 2'b00);
      end
    end

    repeat (3) @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Command-driven AXI-Lite initiator (master) that issues single-beat reads and writes to peripheral slaves, e.g. the UART and other register-mapped blocks on the AXI_LITE bus.
- Accepts one command at a time from a local requester (test sequencer, UART command parser, DMA control FSM) and returns one response per command.
- Drives the same signal set the bus slaves expect, including wlast/rlast; every beat is a single transfer.

Parameters:
ADDR_W, 32, address width of cmd_addr, awaddr, araddr
DATA_W, 32, data width of wdata, rdata, cmd_wdata, rsp_rdata
TIMEOUT_CYCLES, 1024, response-wait limit when AXI_LITE_MASTER_TIMEOUT_EN is defined; must be >= 2

Ports:
aclk  in  1  bus clock
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  master accepts command (high only in IDLE)
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  bresp/rresp; 2'b11 on timeout
awaddr  out  ADDR_W  write address
awvalid  out  1  write-address valid
awready  in  1  write-address ready
wdata  out  DATA_W  write data
wvalid  out  1  write-data valid
wlast  out  1  driven equal to wvalid
wready  in  1  write-data ready
bvalid  in  1  write response valid
bresp  in  2  write response code
bready  out  1  write response ready
araddr  out  ADDR_W  read address
arvalid  out  1  read-address valid
arready  in  1  read-address ready
rdata  in  DATA_W  read data
rvalid  in  1  read data valid
rlast  in  1  last read beat; ignored, single beat assumed
rready  out  1  read data ready

Behaviour:
- Reset (async, aresetn=0):
  - All valid/ready outputs 0, rsp_rdata/rsp_resp 0, FSM=IDLE.
  - Takes effect mid-transaction; no response is emitted for the aborted command.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch addr/data/write into registers.
  - Write: awvalid=wvalid=wlast=bready=1, go WR.
  - Read: arvalid=1, go RD_ADDR.
  - Latency from command acceptance to bus valid: 1 cycle (registered outputs).
- WR:
  - awvalid drops the cycle after awready sampled high.
  - wvalid/wlast drop the cycle after wready sampled high.
  - The two handshakes are independent and may occur in either order or the same cycle.
  - When both are done, go WR_RESP.
  - bready stays 1 from IDLE exit until B is accepted, so a bvalid pulse arriving while still in WR is accepted; rsp_resp=bresp, go RESP.
- WR_RESP: on bvalid&bready, capture bresp, bready=0, go RESP.
- RD_ADDR:
  - On arready, arvalid=0 and rready=1 next cycle, go RD_DATA.
  - rready is also held 1 while arvalid is asserted, because slaves may require rready before producing data.
- RD_DATA: on rvalid&rready, capture rdata, rresp=2'b00, rready=0, go RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_valid never overlaps cmd_ready.
- Outputs hold stable while valid is high and ready is low (AXI rule). No combinational path from any input to any output.
- Back-to-back commands: minimum 1 idle cycle between rsp_valid and the next accepted command.

Optional Feature:
- Macro: AXI_LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WR or RD_ADDR and increments every cycle in WR/WR_RESP/RD_ADDR/RD_DATA.
  - When it reaches TIMEOUT_CYCLES: drop all bus valids/readies, rsp_resp=2'b11, rsp_rdata=0, go RESP.
  - This covers slaves that silently drop unmapped addresses.
- Undefined: no counter; the master waits indefinitely.

Test Plan:
- Write 0x41 to 0x0000_0004, slave awready at cycle 2, wready at cycle 4, bvalid one-cycle pulse with bresp=00 -> exactly one rsp_valid, rsp_resp=00, awvalid/wvalid each deassert 1 cycle after their handshake.
- Read 0x0000_0000, slave returns rdata=0x0000_005A only while rready=1 -> rsp_rdata=0x5A, rsp_resp=00, rready low the cycle after capture.
- Write with awready and wready high in the same cycle and bvalid while still in WR -> response captured, no hang, one rsp_valid.
- aresetn pulsed low during RD_DATA -> all outputs 0 immediately, no rsp_valid; the next read command completes normally.
- With AXI_LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready -> rsp_valid after 16 cycles with rsp_resp=11, arvalid=0.
- Ten back-to-back alternating write/read commands with random slave ready delays of 0-5 cycles -> ten responses in order, read data matching the last write.
